sejf_lock_controller: RTL
=========================

Name: sejf_lock_controller

Overview:
Sequencing controller for the safe. It consumes the dial counter value and the direction-change pulse from the button decoder, and commits one code digit per direction change. When a full combination has been entered it checks it and opens the safe. It also handles relocking, code reprogramming while open, and a timed lockout after repeated failures. It drives a clear strobe back to the dial counter so each attempt starts from 0.

Parameters:
DIGIT_W, 4, width of one dial digit / counter value
CODE_LEN, 3, digits per combination (>=2)
DEFAULT_CODE, 12'h273, reset code; digit i in bits [i*DIGIT_W +: DIGIT_W] (digit0=3, digit1=7, digit2=2)
MAX_FAIL, 3, consecutive failed attempts that trigger lockout
LOCKOUT_CYC, 1000, lockout duration in clk cycles

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
dial  in  DIGIT_W  current dial counter value
dirch  in  1  one-cycle direction-change pulse from decoder; commits a digit
close_btn  in  1  debounced level; rising edge relocks or aborts
prog_btn  in  1  debounced level; rising edge enters program mode (only when OPEN)
open  out  1  safe open (registered)
locked_out  out  1  lockout active (registered)
err  out  1  one-cycle pulse on failed check
prog_done  out  1  one-cycle pulse when new code is stored
cnt_clr  out  1  one-cycle strobe clearing the dial counter
digit_idx  out  $clog2(CODE_LEN)  digit currently expected

Behaviour:
- Reset (asynchronous, active-high): state IDLE; code=DEFAULT_CODE; idx=0; fail_cnt=0; mism=0; button edge registers=0; all outputs 0.
- Button edges: rising edge is detected as level=1 while the previous registered value=0; 1-cycle detection latency.
- All outputs are registered and update on the clock edge following the state transition.
- IDLE/ENTRY (open=0): on dirch, mism |= (dial != code[idx]).
  - If idx < CODE_LEN-1: idx++.
  - Otherwise: go to CHECK next cycle.
  - First dirch moves IDLE to ENTRY.
- Abort in IDLE/ENTRY: close_btn edge clears idx and mism, pulses cnt_clr, and returns to IDLE.
  - If close_btn edge and dirch fall in the same cycle, close wins and the digit is discarded.
- CHECK (exactly 1 cycle):
  - mism=0: go to OPEN; fail_cnt=0.
  - mism=1: err pulse; fail_cnt++. If fail_cnt reaches MAX_FAIL, go to LOCKOUT; otherwise go to IDLE with a cnt_clr pulse.
  - idx and mism are cleared on exit.
- OPEN: open=1; dirch is ignored.
  - close_btn edge: go to IDLE; open=0; cnt_clr pulse.
  - prog_btn edge: go to PROG; idx=0; cnt_clr pulse.
  - If both edges occur in the same cycle, close wins.
- PROG: open=1. Each dirch writes dial into shadow[idx]; idx++.
  - On the CODE_LEN-th dirch: code <= shadow atomically, prog_done pulse, return to OPEN.
  - close_btn edge in PROG: abort with code unchanged; go to IDLE; open=0; cnt_clr pulse.
- LOCKOUT: locked_out=1. A timer loads LOCKOUT_CYC-1 on entry and counts to 0; dirch and buttons are ignored.
  - When the timer reaches 0: go to IDLE; fail_cnt=0; locked_out=0; cnt_clr pulse.
- digit_idx mirrors idx in every state.
- Reset mid-operation: an asserted rst returns everything to reset values immediately, including code=DEFAULT_CODE. A partial PROG is discarded.
- Illegal state encoding: go to IDLE.

Decomposition:
- Package sejf_pkg holds:
  - state localparams: IDLE, ENTRY, CHECK, OPEN, PROG, LOCKOUT
  - defaults for DIGIT_W and CODE_LEN
- One sub-module, sejf_lockout_timer:
  - down-counter with start input and done pulse
  - parameter CYC
  - async active-high rst
- The edge detectors stay inline.

Test Plan:
All scenarios use the default parameters with LOCKOUT_CYC=20.
- Correct code: dirch with dial=3, then 7, then 2 -> one CHECK cycle, then open=1; err never asserted; fail_cnt=0; digit_idx back to 0.
- Single wrong digit: dirch with dial=3, 5, 2 -> err pulses exactly 1 cycle; cnt_clr pulses; open stays 0; the next attempt 3,7,2 opens.
- Lockout: three wrong attempts (1,1,1 three times) -> locked_out=1 for exactly 20 cycles; dirch with 3,7,2 during lockout has no effect. After lockout: cnt_clr pulse; 3,7,2 opens.
- Reprogram: open, prog_btn edge, dirch with 9,0,4 -> prog_done pulse; close_btn edge -> open=0. Then 3,7,2 fails (err) and 9,0,4 opens.
- Aborts: in PROG after 2 digits, close_btn edge -> code stays 273. In ENTRY, close_btn and dirch in the same cycle -> idx=0 and the digit is dropped.
- Async reset: assert rst mid-PROG and mid-LOCKOUT -> open=0, locked_out=0, code=273 without waiting for a clock edge.

Source files
------------

// File: rtl/sejf_pkg.sv
`default_nettype none
// ============================================================================
// sejf_pkg : shared state encoding and default sizes for the safe lock.
// Rev 1.0
// ============================================================================
package sejf_pkg;

    localparam int DIGIT_W_DEF  = 4;
    localparam int CODE_LEN_DEF = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        PROG    = 3'd4,
        LOCKOUT = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sejf_lockout_timer.sv
`default_nettype none
// ============================================================================
// sejf_lockout_timer : down-counter loaded with CYC-1 on start, done at zero.
// Rev 1.0
// ============================================================================
module sejf_lockout_timer #(
    parameter int CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int W = (CYC > 1) ? $clog2(CYC) : 1;

    logic [W-1:0] cnt;
    logic         running;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            cnt     <= W'(CYC - 1);
            running <= 1'b1;
        end else if (running) begin
            if (cnt == '0) begin
                running <= 1'b0;
            end else begin
                cnt <= cnt - W'(1);
            end
        end
    end

    assign done = running && (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/sejf_lock_controller.sv
`default_nettype none
// ============================================================================
// sejf_lock_controller : digit sequencing, code check, reprogramming, lockout.
// Rev 1.0
// ============================================================================
module sejf_lock_controller
    import sejf_pkg::*;
#(
    parameter int                                DIGIT_W      = DIGIT_W_DEF,
    parameter int                                CODE_LEN     = CODE_LEN_DEF,
    parameter logic [DIGIT_W*CODE_LEN-1:0]       DEFAULT_CODE = 12'h273,
    parameter int                                MAX_FAIL     = 3,
    parameter int                                LOCKOUT_CYC  = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIGIT_W-1:0]          dial,
    input  logic                        dirch,
    input  logic                        close_btn,
    input  logic                        prog_btn,
    output logic                        open,
    output logic                        locked_out,
    output logic                        err,
    output logic                        prog_done,
    output logic                        cnt_clr,
    output logic [$clog2(CODE_LEN)-1:0] digit_idx
);

    localparam int                CODE_W   = DIGIT_W * CODE_LEN;
    localparam int                IDX_W    = $clog2(CODE_LEN);
    localparam int                FAIL_W   = $clog2(MAX_FAIL + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CODE_LEN - 1);

    state_t              state, state_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic                mism, mism_n;
    logic [FAIL_W-1:0]   fail_cnt, fail_cnt_n;
    logic [CODE_W-1:0]   code, code_n, shadow, shadow_n;
    logic                close_prev, prog_prev;
    logic                close_edge, prog_edge;
    logic                err_n, prog_done_n, cnt_clr_n;
    logic                timer_start, timer_done;
    logic [DIGIT_W-1:0]  cur_digit;

    assign close_edge = close_btn & ~close_prev;
    assign prog_edge  = prog_btn & ~prog_prev;
    assign cur_digit  = code[idx*DIGIT_W +: DIGIT_W];
    assign digit_idx  = idx;

    sejf_lockout_timer #(
        .CYC (LOCKOUT_CYC)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (timer_start),
        .done  (timer_done)
    );

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        mism_n      = mism;
        fail_cnt_n  = fail_cnt;
        code_n      = code;
        shadow_n    = shadow;
        err_n       = 1'b0;
        prog_done_n = 1'b0;
        cnt_clr_n   = 1'b0;
        timer_start = 1'b0;
        case (state)
            IDLE, ENTRY: begin
                // A close edge in the same cycle as dirch discards that digit.
                if (close_edge) begin
                    state_n   = IDLE;
                    idx_n     = '0;
                    mism_n    = 1'b0;
                    cnt_clr_n = 1'b1;
                end else if (dirch) begin
                    mism_n = mism | (dial != cur_digit);
                    if (idx == LAST_IDX) begin
                        state_n = CHECK;
                    end else begin
                        idx_n   = idx + IDX_W'(1);
                        state_n = ENTRY;
                    end
                end
            end
            CHECK: begin
                idx_n  = '0;
                mism_n = 1'b0;
                if (!mism) begin
                    state_n    = OPEN;
                    fail_cnt_n = '0;
                end else begin
                    err_n      = 1'b1;
                    fail_cnt_n = fail_cnt + FAIL_W'(1);
                    if (fail_cnt_n == FAIL_W'(MAX_FAIL)) begin
                        state_n     = LOCKOUT;
                        timer_start = 1'b1;
                    end else begin
                        state_n   = IDLE;
                        cnt_clr_n = 1'b1;
                    end
                end
            end
            OPEN: begin
                if (close_edge) begin
                    state_n   = IDLE;
                    cnt_clr_n = 1'b1;
                end else if (prog_edge) begin
                    state_n   = PROG;
                    idx_n     = '0;
                    cnt_clr_n = 1'b1;
                end
            end
            PROG: begin
                if (close_edge) begin
                    state_n   = IDLE;
                    idx_n     = '0;
                    cnt_clr_n = 1'b1;
                end else if (dirch) begin
                    shadow_n[idx*DIGIT_W +: DIGIT_W] = dial;
                    if (idx == LAST_IDX) begin
                        code_n      = shadow_n;
                        prog_done_n = 1'b1;
                        state_n     = OPEN;
                        idx_n       = '0;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            LOCKOUT: begin
                if (timer_done) begin
                    state_n    = IDLE;
                    fail_cnt_n = '0;
                    cnt_clr_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
                mism_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            mism       <= 1'b0;
            fail_cnt   <= '0;
            code       <= DEFAULT_CODE;
            shadow     <= '0;
            close_prev <= 1'b0;
            prog_prev  <= 1'b0;
            open       <= 1'b0;
            locked_out <= 1'b0;
            err        <= 1'b0;
            prog_done  <= 1'b0;
            cnt_clr    <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            mism       <= mism_n;
            fail_cnt   <= fail_cnt_n;
            code       <= code_n;
            shadow     <= shadow_n;
            close_prev <= close_btn;
            prog_prev  <= prog_btn;
            open       <= (state_n == OPEN) || (state_n == PROG);
            locked_out <= (state_n == LOCKOUT);
            err        <= err_n;
            prog_done  <= prog_done_n;
            cnt_clr    <= cnt_clr_n;
        end
    end

endmodule
`default_nettype wire
